// File: rtl/sparse_expand_engine.sv
// Sparse expand engine: scatters compacted PE lanes back to dense positions by keep-mask.
// Optional build macro SPARSE_EXPAND_STATS_EN adds saturating block / zero-fill counters.
module sparse_expand_engine #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DENSE_N    = 8,
    parameter int unsigned LANES      = 4,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          expand_enable,
    input  logic [LANES*DATA_WIDTH-1:0]   in_data,
    input  logic [DENSE_N-1:0]            in_mask,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [DENSE_N*DATA_WIDTH-1:0] out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic                          overflow_err,
    output logic [31:0]                   stat_blocks,
    output logic [31:0]                   stat_zeros
);
    localparam int unsigned PW   = $clog2(DENSE_N + 1);
    localparam int unsigned LW   = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned PTRW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW   = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned CW1  = CW + 1;
    localparam int unsigned BW   = DENSE_N * DATA_WIDTH;
    localparam logic [PW-1:0] LANES_P = PW'(LANES);

    typedef logic [DATA_WIDTH-1:0] elem_t;

    logic accept;
    logic pop;

    logic                         s1_v_q;
    elem_t [LANES-1:0]            s1_data_q;
    logic [DENSE_N-1:0]           s1_mask_q;
    logic [DENSE_N-1:0][PW-1:0]   s1_prefix_q;
    logic [DENSE_N-1:0]           eff_mask;
    logic [DENSE_N-1:0][PW-1:0]   prefix_d;

    logic                         s2_v_q;
    logic [BW-1:0]                s2_data_q;
    logic [BW-1:0]                dense_d;
    logic [PW-1:0]                popcnt;
    logic                         ovf;

    logic [BW-1:0]                mem_q [FIFO_DEPTH];
    logic [PTRW-1:0]              wr_ptr_q;
    logic [PTRW-1:0]              rd_ptr_q;
    logic [CW-1:0]                count_q;
    logic [CW1-1:0]               credit_used;
    logic                         overflow_q;

    // Every block already inside the pipe holds a FIFO slot, so pushes can never hit a full FIFO.
    assign credit_used = {1'b0, count_q} + CW1'(s1_v_q) + CW1'(s2_v_q);
    assign in_ready    = reset_n && (credit_used < CW1'(FIFO_DEPTH));
    assign accept      = in_valid && in_ready;
    assign out_valid   = (count_q != '0);
    assign pop         = out_valid && out_ready;
    assign out_data    = out_valid ? mem_q[rd_ptr_q] : '0;
    assign overflow_err = overflow_q;

    always_comb begin
        logic [PW-1:0] acc;
        acc = '0;
        for (int i = 0; i < int'(DENSE_N); i++) begin
            eff_mask[i] = expand_enable ? in_mask[i] : (i < int'(LANES));
            prefix_d[i] = acc;
            acc         = acc + PW'(eff_mask[i]);
        end
    end

    always_comb begin
        popcnt = s1_prefix_q[DENSE_N-1] + PW'(s1_mask_q[DENSE_N-1]);
        ovf    = popcnt > LANES_P;
        for (int i = 0; i < int'(DENSE_N); i++) begin
            // Set bits past the LANES-th have no source lane and are zero-filled.
            if (s1_mask_q[i] && (s1_prefix_q[i] < LANES_P)) begin
                dense_d[i*DATA_WIDTH +: DATA_WIDTH] = s1_data_q[s1_prefix_q[i][LW-1:0]];
            end else begin
                dense_d[i*DATA_WIDTH +: DATA_WIDTH] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_v_q      <= 1'b0;
            s1_data_q   <= '0;
            s1_mask_q   <= '0;
            s1_prefix_q <= '0;
            s2_v_q      <= 1'b0;
            s2_data_q   <= '0;
            overflow_q  <= 1'b0;
        end else begin
            s1_v_q <= accept;
            if (accept) begin
                s1_data_q   <= in_data;
                s1_mask_q   <= eff_mask;
                s1_prefix_q <= prefix_d;
            end
            s2_v_q <= s1_v_q;
            if (s1_v_q) begin
                s2_data_q <= dense_d;
                if (ovf) begin
                    overflow_q <= 1'b1;
                end
            end
        end
    end

    function automatic logic [PTRW-1:0] ptr_inc(input logic [PTRW-1:0] p);
        return (p == PTRW'(FIFO_DEPTH - 1)) ? '0 : p + PTRW'(1);
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (s2_v_q) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_q + CW'(s2_v_q) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (s2_v_q) begin
            mem_q[wr_ptr_q] <= s2_data_q;
        end
    end

`ifdef SPARSE_EXPAND_STATS_EN
    logic [31:0]   stat_blocks_q;
    logic [31:0]   stat_zeros_q;
    logic [PW-1:0] kept;
    logic [32:0]   zeros_sum;

    assign kept      = ovf ? LANES_P : popcnt;
    assign zeros_sum = {1'b0, stat_zeros_q} + 33'(PW'(DENSE_N) - kept);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_blocks_q <= '0;
            stat_zeros_q  <= '0;
        end else begin
            if (pop && (stat_blocks_q != 32'hFFFF_FFFF)) begin
                stat_blocks_q <= stat_blocks_q + 32'd1;
            end
            if (s1_v_q) begin
                stat_zeros_q <= zeros_sum[32] ? 32'hFFFF_FFFF : zeros_sum[31:0];
            end
        end
    end

    assign stat_blocks = stat_blocks_q;
    assign stat_zeros  = stat_zeros_q;
`else
    assign stat_blocks = '0;
    assign stat_zeros  = '0;
`endif

endmodule

// File: tb/tb_sparse_expand_engine.sv
// Self-checking bench for sparse_expand_engine: scoreboard of expected dense blocks.
// Stats expectations follow SPARSE_EXPAND_STATS_EN when the bench is built with it.
module tb_sparse_expand_engine;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        expand_enable;
    logic [31:0] in_data;
    logic [7:0]  in_mask;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        overflow_err;
    logic [31:0] stat_blocks;
    logic [31:0] stat_zeros;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];
    int unsigned exp_blocks = 0;
    int unsigned exp_zeros  = 0;
    int          cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sparse_expand_engine #(
        .DATA_WIDTH(8), .DENSE_N(8), .LANES(4), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .expand_enable(expand_enable),
        .in_data(in_data), .in_mask(in_mask), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .overflow_err(overflow_err), .stat_blocks(stat_blocks), .stat_zeros(stat_zeros)
    );

    function automatic logic [63:0] model(input logic [31:0] d, input logic [7:0] m,
                                          input logic en);
        logic [7:0]  em;
        logic [63:0] r;
        int          k;
        em = en ? m : 8'h0F;
        r  = '0;
        k  = 0;
        for (int i = 0; i < 8; i++) begin
            if (em[i]) begin
                if (k < 4) r[i*8 +: 8] = d[k*8 +: 8];
                k++;
            end
        end
        return r;
    endfunction

    function automatic int unsigned zeros_of(input logic [7:0] m, input logic en);
        logic [7:0] em;
        int unsigned pc;
        em = en ? m : 8'h0F;
        pc = 0;
        for (int i = 0; i < 8; i++) pc += em[i];
        return 8 - ((pc > 4) ? 4 : pc);
    endfunction

    function automatic logic [31:0] want_blocks();
`ifdef SPARSE_EXPAND_STATS_EN
        return exp_blocks;
`else
        return 32'd0;
`endif
    endfunction

    function automatic logic [31:0] want_zeros();
`ifdef SPARSE_EXPAND_STATS_EN
        return exp_zeros;
`else
        return 32'd0;
`endif
    endfunction

    // Samples the handshakes for the coming edge, books accepted stimulus, then advances a cycle.
    task automatic tick(output logic acc, output logic pop, output logic [63:0] obs);
        acc = in_valid && in_ready;
        pop = out_valid && out_ready;
        obs = out_data;
        if (acc) begin
            exp_q.push_back(model(in_data, in_mask, expand_enable));
            exp_zeros += zeros_of(in_mask, expand_enable);
        end
        if (pop) exp_blocks++;
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; expand_enable = 1'b1; in_data = '0; in_mask = '0;
        in_valid = 1'b0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 64'h0) begin errors++; $display("FAIL rst_out_data got %h want 0", out_data); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
        checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL rst_overflow got %b want 0", overflow_err); end
        checks++; if (stat_blocks !== 32'd0) begin errors++; $display("FAIL rst_stat_blocks got %0d want 0", stat_blocks); end
        checks++; if (stat_zeros !== 32'd0) begin errors++; $display("FAIL rst_stat_zeros got %0d want 0", stat_zeros); end
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rel_in_ready got %b want 1", in_ready); end
    endtask

    task automatic test_scatter();
        logic acc, pop; logic [63:0] obs, e;
        int lat;
        in_data = {8'd44, 8'd33, 8'd22, 8'd11}; in_mask = 8'b1010_0101;
        expand_enable = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        tick(acc, pop, obs);
        in_valid = 1'b0;
        checks++; if (acc !== 1'b1) begin errors++; $display("FAIL scatter_accept got %b want 1", acc); end
        lat = 0; pop = 1'b0;
        while (!pop && lat < 10) begin lat++; tick(acc, pop, obs); end
        checks++; if (lat !== 3 || !pop) begin errors++; $display("FAIL scatter_latency got %0d want 3", lat); end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
        checks++; if (obs !== 64'h2C00_2100_0016_000B) begin errors++; $display("FAIL scatter_data got %h want 2c002100_0016000b", obs); end
        checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL scatter_no_ovf got %b want 0", overflow_err); end
    endtask

    task automatic test_overflow();
        logic acc, pop; logic [63:0] obs, e;
        int n;
        in_data = {8'd44, 8'd33, 8'd22, 8'd11}; in_mask = 8'h3F; in_valid = 1'b1;
        tick(acc, pop, obs);
        in_valid = 1'b0; n = 0; pop = 1'b0;
        while (!pop && n < 10) begin n++; tick(acc, pop, obs); end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
        checks++; if (!pop || obs !== 64'h0000_0000_2C21_160B) begin errors++; $display("FAIL ovf_data got %h want 000000002c21160b", obs); end
        checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", overflow_err); end
        in_mask = 8'h01; in_valid = 1'b1;
        tick(acc, pop, obs);
        in_valid = 1'b0; n = 0; pop = 1'b0;
        while (!pop && n < 10) begin n++; tick(acc, pop, obs); end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
        checks++; if (!pop || obs !== 64'h0B) begin errors++; $display("FAIL ovf_next_data got %h want 0b", obs); end
        checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %b want 1", overflow_err); end
    endtask

    task automatic test_backpressure();
        logic acc, pop; logic [63:0] obs, e;
        int blk, outs;
        out_ready = 1'b0; blk = 0;
        in_data = $urandom; in_mask = 8'($urandom);
        for (int c = 0; c < 8; c++) begin
            in_valid = 1'b1;
            tick(acc, pop, obs);
            if (acc) begin blk++; in_data = $urandom; in_mask = 8'($urandom); end
        end
        checks++; if (blk !== 4) begin errors++; $display("FAIL bp_accepted got %0d want 4", blk); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b want 0", in_ready); end
        e = (exp_q.size() > 0) ? exp_q[0] : 64'hx;
        checks++; if (out_valid !== 1'b1 || out_data !== e) begin errors++; $display("FAIL bp_head_hold got %b/%h want 1/%h", out_valid, out_data, e); end
        out_ready = 1'b1; outs = 0;
        for (int c = 0; c < 40 && outs < 6; c++) begin
            in_valid = (blk < 6);
            tick(acc, pop, obs);
            if (acc) begin blk++; in_data = $urandom; in_mask = 8'($urandom); end
            if (pop) begin
                outs++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
                checks++; if (obs !== e) begin errors++; $display("FAIL bp_out%0d got %h want %h", outs, obs, e); end
            end
        end
        in_valid = 1'b0;
        checks++; if (blk !== 6 || outs !== 6 || exp_q.size() !== 0) begin errors++; $display("FAIL bp_totals got in=%0d out=%0d left=%0d want 6/6/0", blk, outs, exp_q.size()); end
    endtask

    task automatic test_back_to_back();
        logic acc, pop; logic [63:0] obs, e;
        logic iv;
        int sent, outs, stalls, first, last;
        out_ready = 1'b1; sent = 0; outs = 0; stalls = 0; first = -1; last = -1;
        in_data = $urandom; in_mask = 8'($urandom);
        for (int c = 0; c < 60 && outs < 16; c++) begin
            in_valid = (sent < 16);
            iv = in_valid;
            tick(acc, pop, obs);
            if (iv && !acc) stalls++;
            if (acc) begin sent++; in_data = $urandom; in_mask = 8'($urandom); end
            if (pop) begin
                outs++;
                if (first < 0) first = c;
                last = c;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
                checks++; if (obs !== e) begin errors++; $display("FAIL b2b_out%0d got %h want %h", outs, obs, e); end
            end
        end
        in_valid = 1'b0;
        checks++; if (stalls !== 0) begin errors++; $display("FAIL b2b_in_ready_stalls got %0d want 0", stalls); end
        checks++; if (outs !== 16 || (last - first) !== 15) begin errors++; $display("FAIL b2b_consecutive got outs=%0d span=%0d want 16/15", outs, last - first); end
        checks++; if (stat_blocks !== want_blocks()) begin errors++; $display("FAIL b2b_stat_blocks got %0d want %0d", stat_blocks, want_blocks()); end
        checks++; if (stat_zeros !== want_zeros()) begin errors++; $display("FAIL b2b_stat_zeros got %0d want %0d", stat_zeros, want_zeros()); end
    endtask

    task automatic test_async_reset();
        logic acc, pop; logic [63:0] obs;
        int blk, seen;
        out_ready = 1'b0; blk = 0;
        for (int c = 0; c < 10 && blk < 3; c++) begin
            in_valid = 1'b1; in_data = $urandom; in_mask = 8'hFF;
            tick(acc, pop, obs);
            if (acc) blk++;
        end
        in_valid = 1'b0;
        tick(acc, pop, obs);
        #2 reset_n = 1'b0;
        #1;
        exp_q.delete(); exp_blocks = 0; exp_zeros = 0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ar_out_valid got %b want 0", out_valid); end
        checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL ar_overflow got %b want 0", overflow_err); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL ar_in_ready got %b want 0", in_ready); end
        checks++; if (stat_blocks !== 32'd0 || stat_zeros !== 32'd0) begin errors++; $display("FAIL ar_stats got %0d/%0d want 0/0", stat_blocks, stat_zeros); end
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL ar_release_ready got %b want 1", in_ready); end
        out_ready = 1'b1; seen = 0;
        for (int c = 0; c < 6; c++) begin tick(acc, pop, obs); if (pop) seen++; end
        checks++; if (seen !== 0) begin errors++; $display("FAIL ar_discard got %0d outputs want 0", seen); end
    endtask

    task automatic test_identity();
        logic acc, pop; logic [63:0] obs, e;
        int n;
        expand_enable = 1'b0; in_mask = 8'hF0; in_data = 32'hDDCC_BBAA; in_valid = 1'b1;
        out_ready = 1'b1;
        tick(acc, pop, obs);
        in_valid = 1'b0; n = 0; pop = 1'b0;
        while (!pop && n < 10) begin n++; tick(acc, pop, obs); end
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
        checks++; if (!pop || obs !== {32'h0, 32'hDDCC_BBAA}) begin errors++; $display("FAIL id_data got %h want 00000000ddccbbaa", obs); end
        checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL id_overflow got %b want 0", overflow_err); end
        checks++; if (stat_blocks !== want_blocks()) begin errors++; $display("FAIL id_stat_blocks got %0d want %0d", stat_blocks, want_blocks()); end
        checks++; if (stat_zeros !== want_zeros()) begin errors++; $display("FAIL id_stat_zeros got %0d want %0d", stat_zeros, want_zeros()); end
        expand_enable = 1'b1;
    endtask

    initial begin
        test_reset();
        test_scatter();
        test_overflow();
        test_backpressure();
        test_back_to_back();
        test_async_reset();
        test_identity();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end
endmodule
